// File: rtl/ppm16_rx_ctrl.sv
// ppm16_rx_ctrl: receive-side sequencer for the 16-ary PPM demodulator.
// It arms the demodulator and supervises its preamble search with a
// timeout. Pairs of 4-bit symbols are packed into bytes and written to
// the RX FIFO. Packet end, search timeout and FIFO overflow are reported.
// Every output comes straight from a flop.
module ppm16_rx_ctrl #(
  parameter int TIMEOUT_BITS = 16,
  parameter int COUNT_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [TIMEOUT_BITS-1:0] timeout_cycles,
  input  logic                    clear_flags,
  input  logic [2:0]              demod_state,
  input  logic                    demod_packet_detected,
  input  logic                    demod_dout_valid,
  input  logic [3:0]              demod_dout,
  output logic                    demod_rx_start,
  output logic                    demod_abort_n,
  output logic [7:0]              fifo_wdata,
  output logic                    fifo_wvalid,
  input  logic                    fifo_full,
  output logic                    busy,
  output logic                    pkt_done,
  output logic                    timeout,
  output logic                    overflow,
  output logic [COUNT_BITS-1:0]   byte_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_SEARCH  = 3'd2;
  localparam logic [2:0] ST_RECEIVE = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ABORT   = 3'd6;

  localparam logic [2:0] DEMOD_IDLE = 3'd0;

  logic [2:0]              state_q,    state_d;
  logic [TIMEOUT_BITS-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic                    pend_q,     pend_d;
  logic [3:0]              high_q,     high_d;
  logic [7:0]              wdata_q,    wdata_d;
  logic                    wvalid_q,   wvalid_d;
  logic [COUNT_BITS-1:0]   count_q,    count_d;
  logic                    ovf_q,      ovf_d;
  logic                    rx_start_q, rx_start_d;
  logic                    abort_n_q,  abort_n_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;
  logic                    timeout_q,  timeout_d;

  // Set for one cycle when a byte is ready for the FIFO. A byte is ready
  // when a nibble pair completes in RECEIVE, or when FLUSH pads out a lone
  // high nibble.
  logic       byte_vld;
  logic [7:0] byte_val;

  // Sequencer next state, search timer and nibble packer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    pend_d    = pend_q;
    high_d    = high_q;
    timeout_d = 1'b0;
    byte_vld  = 1'b0;
    byte_val  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_START;
      end

      ST_START: begin
        tmo_cnt_d = '0;
        pend_d    = 1'b0;
        state_d   = ST_SEARCH;
      end

      ST_SEARCH: begin
        tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
        // A detected packet wins over both abort reasons.
        if (demod_packet_detected) begin
          state_d = ST_RECEIVE;
        end else if (!enable) begin
          state_d = ST_ABORT;
        end else if ((timeout_cycles != '0) &&
                     (tmo_cnt_q == timeout_cycles - TIMEOUT_BITS'(1))) begin
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end
      end

      ST_RECEIVE: begin
        if (demod_dout_valid) begin
          if (!pend_q) begin
            high_d = demod_dout;
            pend_d = 1'b1;
          end else begin
            byte_vld = 1'b1;
            byte_val = {high_q, demod_dout};
            pend_d   = 1'b0;
          end
        end
        // The packet ends when the demodulator returns to idle. Any symbol
        // arriving in that same cycle has already been folded into pend_d.
        // Enable is ignored here so that a packet is never cut short.
        if (demod_state == DEMOD_IDLE) begin
          state_d = pend_d ? ST_FLUSH : ST_DONE;
        end
      end

      ST_FLUSH: begin
        byte_vld = 1'b1;
        byte_val = {high_q, 4'h0};
        pend_d   = 1'b0;
        state_d  = ST_DONE;
      end

      ST_DONE, ST_ABORT: begin
        state_d = enable ? ST_START : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO write, byte counter, sticky overflow and the registered status pulses.
  always_comb begin
    // A byte that meets a full FIFO is dropped and does not count.
    wvalid_d = byte_vld && !fifo_full;
    wdata_d  = byte_vld ? byte_val : wdata_q;

    if (state_d == ST_START) begin
      count_d = '0;
    end else if (wvalid_d && (count_q != '1)) begin
      count_d = count_q + COUNT_BITS'(1);
    end else begin
      count_d = count_q;
    end

    // If a drop and clear_flags happen in the same cycle, the drop wins.
    if (byte_vld && fifo_full) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    rx_start_d = (state_d == ST_START);
    abort_n_d  = (state_d != ST_ABORT);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      pend_q     <= 1'b0;
      high_q     <= 4'h0;
      wdata_q    <= 8'h00;
      wvalid_q   <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rx_start_q <= 1'b0;
      abort_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge, whatever the statement order.
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pend_q     <= pend_d;
      high_q     <= high_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rx_start_q <= rx_start_d;
      abort_n_q  <= abort_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign demod_rx_start = rx_start_q;
  assign demod_abort_n  = abort_n_q;
  assign fifo_wdata     = wdata_q;
  assign fifo_wvalid    = wvalid_q;
  assign busy           = busy_q;
  assign pkt_done       = done_q;
  assign timeout        = timeout_q;
  assign overflow       = ovf_q;
  assign byte_count     = count_q;

endmodule
